// File: rtl/counter_capture_fifo.sv
// counter_capture_fifo: captures {epoch, count} timestamps into a small
// circular FIFO and presents the oldest entry on a valid/ready port.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   count, overflow       free-running counter value and its wrap pulse
//   capture               timestamp capture request, sampled every cycle
//   out_valid/out_ready   head-entry handshake to the consumer
//   out_epoch/out_count   head entry fields
//   level                 entries held (0..DEPTH)
//   dropped, drop_cnt     sticky loss flag and saturating loss count
module counter_capture_fifo #(
   parameter int DEPTH   = 4,
   parameter int EPOCH_W = 16,
   parameter int LVL_W   = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        count,
   input  logic               overflow,
   input  logic               capture,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [EPOCH_W-1:0] out_epoch,
   output logic [31:0]        out_count,
   output logic [LVL_W-1:0]   level,
   output logic               dropped,
   output logic [7:0]         drop_cnt
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [EPOCH_W-1:0] r_mem_epoch [DEPTH];
   logic [31:0]        r_mem_count [DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [LVL_W-1:0]   r_level;
   logic [EPOCH_W-1:0] r_epoch;
   logic               r_dropped;
   logic [7:0]         r_drop_cnt;

   logic               w_full;
   logic               w_pop;
   logic               w_push;
   logic               w_drop;
   logic [EPOCH_W-1:0] w_entry_epoch;

   // The entry epoch already includes this cycle's overflow, so a capture
   // on the wrap cycle pairs count=0 with the new epoch.
   assign w_entry_epoch = r_epoch + EPOCH_W'(overflow);

   assign w_full = (r_level == LVL_W'(DEPTH));
   assign w_pop  = out_valid & out_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign w_push = capture & (~w_full | w_pop);
   assign w_drop = capture & w_full & ~w_pop;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem_epoch[i] <= '0;
            r_mem_count[i] <= '0;
         end
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_epoch    <= '0;
         r_dropped  <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         r_epoch <= w_entry_epoch;
         if (w_push) begin
            r_mem_epoch[r_wr_ptr] <= w_entry_epoch;
            r_mem_count[r_wr_ptr] <= count;
            r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_level <= r_level + LVL_W'(1);
         end else if (!w_push && w_pop) begin
            r_level <= r_level - LVL_W'(1);
         end
         if (w_drop) begin
            r_dropped <= 1'b1;
            if (r_drop_cnt != 8'hFF) begin
               r_drop_cnt <= r_drop_cnt + 8'd1;
            end
         end
      end
   end

   // Outputs come straight from registers: no path from capture.
   assign out_valid = (r_level != '0);
   assign out_epoch = r_mem_epoch[r_rd_ptr];
   assign out_count = r_mem_count[r_rd_ptr];
   assign level     = r_level;
   assign dropped   = r_dropped;
   assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_counter_capture_fifo.sv
// Bench for counter_capture_fifo: queue-based reference model and a
// scoreboard monitor checking head entries as the DUT presents them.
module tb_counter_capture_fifo;

   localparam int DEPTH = 4;
   localparam int EW    = 2;
   localparam int LW    = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [EW-1:0] ep;
      logic [31:0]   c;
   } ent_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [31:0]   count = '0;
   logic          overflow = 1'b0;
   logic          capture = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [EW-1:0] out_epoch;
   logic [31:0]   out_count;
   logic [LW-1:0] level;
   logic          dropped;
   logic [7:0]    drop_cnt;

   counter_capture_fifo #(.DEPTH(DEPTH), .EPOCH_W(EW)) dut (
      .clk(clk), .reset(reset), .count(count), .overflow(overflow),
      .capture(capture), .out_valid(out_valid), .out_ready(out_ready),
      .out_epoch(out_epoch), .out_count(out_count), .level(level),
      .dropped(dropped), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   int   total = 0;
   int   bad = 0;
   bit   started = 0;
   ent_t exp_q[$];

   // reference model state
   int m_level = 0;
   int m_epoch = 0;
   bit m_dropped = 0;
   int m_drop_cnt = 0;

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp,
                  $time);
      end
   endtask

   // Scoreboard monitor: head must match the oldest expected entry
   // in every cycle it is valid; an accepted head retires it.
   always @(negedge clk) begin
      if (started && !reset && out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL head: got valid entry, expected none at %0t",
                     $time);
         end else begin
            chk("head_epoch", 64'(out_epoch), 64'(exp_q[0].ep));
            chk("head_count", 64'(out_count), 64'(exp_q[0].c));
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic cyc(input bit rst, input bit cap, input logic [31:0] cnt,
                      input bit ov, input bit rdy);
      bit   pop, full;
      ent_t e;
      reset = rst;
      capture = cap;
      count = cnt;
      overflow = ov;
      out_ready = rdy;
      if (rst) begin
         m_level = 0;
         m_epoch = 0;
         m_dropped = 0;
         m_drop_cnt = 0;
         exp_q.delete();
      end else begin
         pop = (m_level != 0) && rdy;
         full = (m_level == DEPTH);
         m_epoch = (m_epoch + int'(ov)) % (1 << EW);
         if (cap && (!full || pop)) begin
            e.ep = EW'(m_epoch);
            e.c = cnt;
            exp_q.push_back(e);
            if (!pop) m_level++;
         end else begin
            if (pop) m_level--;
            if (cap) begin
               m_dropped = 1;
               if (m_drop_cnt < 255) m_drop_cnt++;
            end
         end
      end
      @(posedge clk);
      #1;
      started = 1;
      chk("level", 64'(level), 64'(m_level));
      chk("valid", 64'(out_valid), 64'(m_level != 0));
      chk("dropped", 64'(dropped), 64'(m_dropped));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drop_cnt));
      #1;
   endtask

   initial begin
      @(posedge clk);
      #2;
      // reset, then first capture held for 5 cycles
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      chk("rst_epoch", 64'(out_epoch), 64'd0);
      chk("rst_count", 64'(out_count), 64'd0);
      cyc(0, 1, 32'h10, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1);
      // fill past full
      for (int i = 0; i < 6; i++) cyc(0, 1, 32'(100 + i), 0, 0);
      chk("fill_level", 64'(level), 64'd4);
      chk("fill_dcnt", 64'(drop_cnt), 64'd2);
      // push and pop while full
      cyc(0, 1, 32'd200, 0, 1);
      chk("pp_level", 64'(level), 64'd4);
      chk("pp_dcnt", 64'(drop_cnt), 64'd2);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1);
      // capture on the wrap cycle
      cyc(0, 1, 32'hFFFF_FFFF, 0, 0);
      cyc(0, 1, 32'h0, 1, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
      // epoch wraps back to its start after 2^EW overflows
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
      cyc(0, 1, 32'h55, 0, 0);
      cyc(0, 0, 0, 0, 1);
      // random traffic with varying consumer pressure
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom_range(0, 149) == 0), $urandom_range(0, 1),
             $urandom, ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 3) < ((i / 100) % 4)));
      end
      // drop saturation
      for (int i = 0; i < 300; i++) cyc(0, 1, 32'(i), 0, 0);
      chk("sat_dcnt", 64'(drop_cnt), 64'd255);
      cyc(0, 1, 32'd7, 0, 0);
      chk("sat_hold", 64'(drop_cnt), 64'd255);
      // reset mid-operation with a capture in the reset cycle
      cyc(0, 0, 0, 0, 1);
      chk("mid_level", 64'(level), 64'd3);
      cyc(1, 1, 32'hABCD, 1, 0);
      chk("mr_level", 64'(level), 64'd0);
      chk("mr_drop", 64'(dropped), 64'd0);
      cyc(0, 0, 0, 0, 1);
      chk("mr_valid", 64'(out_valid), 64'd0);
      cyc(0, 1, 32'h77, 0, 0);
      chk("mr_epoch", 64'(out_epoch), 64'd0);
      cyc(0, 0, 0, 0, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
